// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter with sticky drain interrupt.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx #(
   parameter int unsigned WAIT_COUNT = 868,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       we,
   input  logic       ien,
   input  logic       ack,
   output logic       tx,
   output logic       busy,
   output logic       full,
   output logic       irq
);

   localparam int unsigned CNT_W = $clog2(WAIT_COUNT + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   if (WAIT_COUNT < 2) begin : g_bad_wait
      $error("WAIT_COUNT must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   waitcnt_q, waitcnt_d;
   logic [2:0]         bitcnt_q, bitcnt_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               full_q, full_d;
   logic               irq_q, irq_d;

   logic               push;
   logic               pop;
   logic               buf_empty;
   logic               nonempty_d;
   logic [7:0]         head;
   logic               bit_end;
   logic               irq_set;

   // full is the occupancy at the start of the cycle, so a same-cycle pop never makes room
   assign push = we && !full_q;

`ifdef UART_TX_FIFO_EN
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [7:0]        mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FCNT_W-1:0] count_q, count_d;

   assign buf_empty = (count_q == '0);
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = tx_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + FCNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - FCNT_W'(1);
      end
      nonempty_d = (count_d != '0);
      full_d     = (count_d == FCNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
`else
   logic [7:0] hold_q, hold_d;
   logic       valid_q, valid_d;

   assign buf_empty = !valid_q;
   assign head      = hold_q;

   always_comb begin
      hold_d  = hold_q;
      valid_d = valid_q;
      if (pop) begin
         valid_d = 1'b0;
      end
      if (push) begin
         hold_d  = tx_data;
         valid_d = 1'b1;
      end
      nonempty_d = valid_d;
      full_d     = valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   end
`endif

   assign bit_end = (waitcnt_q == CNT_W'(WAIT_COUNT - 1));

   // Frame sequencing: start, 8 data bits LSB first, stop; back-to-back when data waits
   always_comb begin
      state_d   = state_q;
      waitcnt_d = waitcnt_q;
      bitcnt_d  = bitcnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;
      irq_set   = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!buf_empty) begin
               pop       = 1'b1;
               shift_d   = head;
               tx_d      = 1'b0;
               waitcnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               waitcnt_d = '0;
               bitcnt_d  = '0;
               tx_d      = shift_q[0];
               state_d   = DATA;
            end else begin
               waitcnt_d = waitcnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               waitcnt_d = '0;
               if (bitcnt_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  shift_d  = {1'b1, shift_q[7:1]};
                  tx_d     = shift_q[1];
               end
            end else begin
               waitcnt_d = waitcnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               waitcnt_d = '0;
               if (!buf_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  irq_set = ien;
                  state_d = IDLE;
               end
            end else begin
               waitcnt_d = waitcnt_q + CNT_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE) || nonempty_d;
      // A set in the same cycle as ack wins
      irq_d  = irq_set || (irq_q && !ack);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         waitcnt_q <= '0;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         full_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitcnt_q <= waitcnt_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         full_q    <= full_d;
         irq_q     <= irq_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign full = full_q;
   assign irq  = irq_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor decodes frames.
// Builds for either buffer variant (UART_TX_FIFO_EN defined or not).
module tb_uart_tx;

   localparam int unsigned W     = 4;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       we;
   logic       ien;
   logic       ack;
   logic       tx;
   logic       busy;
   logic       full;
   logic       irq;

   int checks = 0;
   int errors = 0;
   int frames = 0;
   int cyc    = 0;
   logic [7:0] exp_q [$];

   uart_tx #(.WAIT_COUNT(W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .we(we), .ien(ien), .ack(ack),
      .tx(tx), .busy(busy), .full(full), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [7:0] b);
      tx_data = b;
      we      = 1'b1;
      tick();
      we      = 1'b0;
   endtask

   // Advance until busy drops; returns the edge count at which it was seen low
   task automatic wait_idle(input int limit, output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < limit; i++) begin
         if (busy === 1'b0) begin
            at_cyc = cyc;
            break;
         end
         tick();
      end
      if (at_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: busy still %b after %0d cycles", busy, limit);
      end
   endtask

   task automatic wait_not_full(input int limit);
      int i;
      for (i = 0; i < limit && full !== 1'b0; i++) tick();
      if (i == limit) begin
         checks++;
         errors++;
         $display("FAIL wait_not_full: full still %b after %0d cycles", full, limit);
      end
   endtask

   // Line monitor: every level must hold exactly W samples; decoded byte checked against the queue
   initial begin : monitor
      logic [9:0] bits;
      logic       aborted;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || tx !== 1'b0) continue;
         aborted = 1'b0;
         bits    = '0;
         for (int b = 0; b < 10 && !aborted; b++) begin
            for (int c = 0; c < int'(W); c++) begin
               if (b != 0 || c != 0) @(negedge clk);
               if (rst !== 1'b0) begin
                  aborted = 1'b1;
                  break;
               end
               if (c == 0) bits[b] = tx;
               else check("bit_hold", tx, bits[b]);
            end
         end
         if (!aborted) begin
            frames++;
            check("start_bit", bits[0], 1'b0);
            check("stop_bit", bits[9], 1'b1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got byte %0h with nothing expected", bits[8:1]);
            end else begin
               check("frame_data", bits[8:1], exp_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int   t_w;
      int   t_f;
      int   f0;
      logic idle_ok;

      rst = 1'b1; we = 1'b0; tx_data = '0; ien = 1'b0; ack = 1'b0;
      tick();
      tick();
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_full", full, 1'b0);
      check("reset_irq", irq, 1'b0);
      rst = 1'b0;

      idle_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
      end
      check("idle_line", idle_ok, 1'b1);

      // Single byte: exact latency and frame length
      exp_q.push_back(8'hA5);
      write(8'hA5);
      t_w = cyc;
      check("busy_on_accept", busy, 1'b1);
      check("tx_before_start", tx, 1'b1);
      tick();
      check("tx_start_edge", tx, 1'b0);
      wait_idle(200, t_f);
      check("busy_fall_a5", t_f - t_w, 41);
      check("irq_ien0", irq, 1'b0);
      repeat (3) tick();

      // Two bytes back to back: no idle gap, 80 cycles of line activity
      f0 = frames;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      write(8'h00);
      t_w = cyc;
`ifdef UART_TX_FIFO_EN
      write(8'hFF);
`else
      wait_not_full(50);
      write(8'hFF);
`endif
      wait_idle(300, t_f);
      check("busy_span_2frames", t_f - t_w, 81);
      check("frames_2", frames - f0, 2);
      repeat (3) tick();

      // Writes issued while full are dropped
      f0 = frames;
`ifdef UART_TX_FIFO_EN
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 5; i++) write(8'(i));
      check("full_at_depth", full, 1'b1);
      write(8'h06);
      wait_idle(800, t_f);
      check("frames_fifo", frames - f0, 5);
`else
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h33);
      write(8'h11);
      check("full_after_write", full, 1'b1);
      write(8'h22);
      check("full_freed_by_pop", full, 1'b0);
      write(8'h33);
      check("full_after_queue", full, 1'b1);
      wait_idle(400, t_f);
      check("frames_hold", frames - f0, 2);
`endif
      repeat (3) tick();

      // Interrupt: set on drain, ien=0 does not clear, ack clears
      ien = 1'b1;
      exp_q.push_back(8'h5A);
      write(8'h5A);
      check("irq_not_yet", irq, 1'b0);
      wait_idle(200, t_f);
      check("irq_set_on_drain", irq, 1'b1);
      ien = 1'b0;
      tick();
      tick();
      check("irq_sticky_ien0", irq, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("irq_ack_clear", irq, 1'b0);

      // Ack held across the set cycle: set wins, then ack clears
      ien = 1'b1;
      ack = 1'b1;
      exp_q.push_back(8'h3C);
      write(8'h3C);
      wait_idle(200, t_f);
      check("irq_set_beats_ack", irq, 1'b1);
      tick();
      check("irq_ack_after_set", irq, 1'b0);
      ack = 1'b0;
      ien = 1'b0;
      repeat (3) tick();

      // Reset during data bit 3 with bytes queued: frame aborted, queue discarded
      f0 = frames;
      write(8'h81);
      t_w = cyc;
`ifdef UART_TX_FIFO_EN
      write(8'h42);
      write(8'h24);
`else
      wait_not_full(50);
      write(8'h42);
`endif
      check("queued_busy", busy, 1'b1);
      while (cyc < t_w + 1 + 4 * int'(W) + 1) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_full", full, 1'b0);
      idle_ok = 1'b1;
      for (int i = 0; i < 30 * int'(W); i++) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
      end
      check("no_frames_after_rst", idle_ok, 1'b1);
      check("frames_after_rst", frames - f0, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
